// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution output writer.
// Holds the FSM state enum and the magnitude/saturation function.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [7:0] SAT_LIMIT = 8'd255;

    // |x| in 17 bits so -32768 maps to 32768, then clamp to one byte
    function automatic logic [7:0] mag_sat8(input logic signed [15:0] x);
        logic [16:0] mag;
        mag = x[15] ? (17'd0 - {x[15], x}) : {1'b0, x};
        if (mag > {9'd0, SAT_LIMIT}) begin
            return SAT_LIMIT;
        end
        return mag[7:0];
    endfunction

endpackage

// File: rtl/conv_writer_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count.
// A push while full is taken when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/conv_writer.sv
// Converts convolution results to saturated magnitudes and writes
// them to a frame buffer through a FIFO, one frame per start.
module conv_writer
    import conv_pkg::*;
#(
    parameter int IMG_W      = 3,
    parameter int IMG_H      = 3,
    parameter int ADDR_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [15:0]       pxl_in,
    input  logic              pxl_valid,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    input  logic              mem_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int N  = IMG_W * IMG_H;
    localparam int CW = ADDR_W + 1;
    localparam int EW = ADDR_W + 8;

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   cnt;
    logic            collect;
    logic            take;
    logic            last;
    logic            pop;
    logic            full;
    logic            empty;
    logic [EW-1:0]   wentry;
    logic [EW-1:0]   head;

    assign collect = (state == S_COLLECT);
    assign take    = collect && pxl_valid;
    assign last    = (cnt == CW'(N - 1));
    assign pop     = !empty && mem_ready;
    assign wentry  = {cnt[ADDR_W-1:0], mag_sat8(pxl_in)};

    assign mem_we   = !empty;
    assign mem_addr = empty ? '0 : head[EW-1:8];
    assign mem_data = empty ? '0 : head[7:0];

    sync_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (take),
        .pop   (pop),
        .wdata (wentry),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_IDLE;
        else        state <= state_nx;
    end

    // Next-state and status outputs
    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_COLLECT;
            end
            S_COLLECT: begin
                busy = 1'b1;
                if (take && last) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                busy = 1'b1;
                if (empty) state_nx = S_DONE;
            end
            S_DONE: begin
                done     = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Sample counter; dropped samples still advance it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (state == S_IDLE && start) begin
            cnt <= '0;
        end else if (take) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Sticky drop flag, cleared when a frame is armed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (state == S_IDLE && start) begin
            overflow <= 1'b0;
        end else if (take && full && !pop) begin
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_conv_writer.sv
// Scoreboard bench for conv_writer: expected writes are queued as
// samples are driven and matched against the frame-buffer port.
module tb_conv_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] pxl_in;
    logic        pxl_valid;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [7:0]  mem_data;
    logic        mem_ready;
    logic        busy;
    logic        done;
    logic        overflow;

    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int base = 0;
    int idx = 0;
    logic [15:0] sbq [$];

    conv_writer dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .pxl_in    (pxl_in),
        .pxl_valid (pxl_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_mag(input int v);
        int a;
        a = (v < 0) ? -v : v;
        return (a > 255) ? 8'd255 : 8'(a);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame();
        base  = done_cnt;
        idx   = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic send(input int v, input bit store);
        logic [7:0] a;
        pxl_in    = 16'(v);
        pxl_valid = 1'b1;
        a = 8'(idx);
        if (store) sbq.push_back({a, ref_mag(v)});
        idx++;
        step();
        pxl_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 200 && done_cnt == base; i++) step();
        chk("done_seen", 32'(done_cnt != base), 1);
        repeat (3) step();
        chk("done_once", done_cnt - base, 1);
        chk("sb_empty", sbq.size(), 0);
        chk("busy_idle", busy, 0);
    endtask

    // Write-port monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (done) begin
                done_cnt++;
                chk("busy_at_done", busy, 0);
            end
            if (mem_we && mem_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_write", {24'd0, mem_addr}, 32'hFFFF);
                end else begin
                    chk("wr_addr", mem_addr, sbq[0][15:8]);
                    chk("wr_data", mem_data, sbq[0][7:0]);
                    void'(sbq.pop_front());
                end
            end else if (mem_we && sbq.size() > 0) begin
                chk("stall_addr", mem_addr, sbq[0][15:8]);
                chk("stall_data", mem_data, sbq[0][7:0]);
            end
        end
    end

    initial begin
        int nom [9];
        int d0;
        nom = '{0, 100, -100, 255, 256, -32768, 32767, -1, 7};
        reset = 1'b0;
        start = 1'b0;
        pxl_in = '0;
        pxl_valid = 1'b0;
        mem_ready = 1'b1;
        repeat (2) step();
        chk("rst_we", mem_we, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_data", mem_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", overflow, 0);
        reset = 1'b1;
        step();

        // nominal frame
        start_frame();
        for (int i = 0; i < 9; i++) send(nom[i], 1'b1);
        wait_done();
        chk("nom_ovf", overflow, 0);

        // backpressure, exactly fills the FIFO
        start_frame();
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(10 * i - 15, 1'b1);
        step();
        chk("bp_ovf", overflow, 0);
        mem_ready = 1'b1;
        for (int i = 4; i < 9; i++) send(i * 3, 1'b1);
        wait_done();
        chk("bp_ovf_end", overflow, 0);

        // overflow: samples 4 and 5 dropped
        start_frame();
        mem_ready = 1'b0;
        for (int i = 0; i < 6; i++) send(-(i + 1) * 50, i < 4);
        chk("ovf_set", overflow, 1);
        mem_ready = 1'b1;
        for (int i = 6; i < 9; i++) send(i + 200, 1'b1);
        wait_done();
        chk("ovf_hold", overflow, 1);

        // push while full with concurrent pop
        start_frame();
        chk("ovf_cleared", overflow, 0);
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(i + 1, 1'b1);
        mem_ready = 1'b1;
        send(-300, 1'b1);
        chk("pp_ovf", overflow, 0);
        for (int i = 5; i < 9; i++) send(-i, 1'b1);
        wait_done();
        chk("pp_ovf_end", overflow, 0);

        // pxl_valid in IDLE is ignored
        pxl_in = 16'd42;
        pxl_valid = 1'b1;
        repeat (3) step();
        pxl_valid = 1'b0;
        chk("idle_no_we", mem_we, 0);
        chk("idle_busy", busy, 0);

        // start during COLLECT does not restart the count
        start_frame();
        send(11, 1'b1);
        send(-12, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 2; i < 9; i++) send(1000 + i, 1'b1);
        wait_done();

        // reset in DRAIN aborts the frame without done
        start_frame();
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) send(i + 20, i < 4);
        chk("drain_busy", busy, 1);
        reset = 1'b0;
        #1;
        chk("abort_we", mem_we, 0);
        chk("abort_addr", mem_addr, 0);
        chk("abort_data", mem_data, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ovf", overflow, 0);
        sbq.delete();
        d0 = done_cnt;
        repeat (3) step();
        reset = 1'b1;
        mem_ready = 1'b1;
        repeat (5) step();
        chk("abort_no_done", done_cnt, d0);
        start_frame();
        for (int i = 0; i < 9; i++) send(nom[8 - i], 1'b1);
        wait_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
